// File: rtl/sha256_w_expander_stream.sv
// SHA-256 message-schedule expander with a streaming interface.
// Takes one 512-bit message block (W0..W15) and emits W0..W63 as a
// stream of LANES words per beat. The lowest-index word sits in the most
// significant lane.
//
// Handshake: a transfer happens on a side only in a cycle where that
// side's valid and ready are both high at the rising edge of CLK. The
// producer holds valid and data steady until the transfer completes.
// out_valid does not depend on out_ready. in_ready depends on out_ready
// only during the last beat of a block, which allows back-to-back blocks
// with no idle cycle between them.
module sha256_w_expander_stream #(
    parameter int LANES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [511:0]          block_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   out_words,
    output logic [5:0]            out_idx,
    output logic                  out_last
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("sha256_w_expander_stream: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(64 - LANES);
    localparam logic [5:0] STEP     = 6'(LANES);

    state_t      state;
    logic [5:0]  idx;
    // win[i] holds W[idx+i]
    logic [31:0] win [16];
    // Window followed by this beat's freshly computed words
    logic [31:0] ext [16+LANES];

    logic in_fire;
    logic out_fire;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign out_valid = (state == EXPAND);
    assign out_idx   = idx;
    assign out_last  = (state == EXPAND) && (idx == LAST_IDX);
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // New words for this beat. Lanes at or beyond 2 (and lane 7 for
    // W[k-7] when LANES=8) read words produced earlier in the same beat.
    // Words past W63 are never needed and are left as zero.
    always_comb begin
        ext = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            ext[i] = win[i];
        end
        for (int j = 0; j < LANES; j++) begin
            if ((7'(idx) + 7'(16 + j)) > 7'd63) begin
                ext[16+j] = '0;
            end else begin
                ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
            end
        end
    end

    // Output lanes come straight from the head of the window
    always_comb begin
        out_words = '0;
        for (int j = 0; j < LANES; j++) begin
            out_words[LANES*32-1-32*j -: 32] = win[j];
        end
    end

    // State, index counter and window update; reset wins over both handshakes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (in_fire) begin
            state <= EXPAND;
            idx   <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= block_in[511-32*i -: 32];
            end
        end else if (out_fire) begin
            if (out_last) begin
                state <= IDLE;
            end else begin
                idx <= idx + STEP;
                for (int i = 0; i < 16; i++) begin
                    win[i] <= ext[i+LANES];
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_w_expander_stream.sv
// Directed bench for sha256_w_expander_stream: one instance per lane
// count (1, 2, 4, 8) sharing stimulus, with a software schedule model
// feeding an expected-word queue.
module tb_sha256_w_expander_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic [511:0] block_in;
  logic         out_ready;
  int           sel;

  logic         iv1, iv2, iv4, iv8;
  logic         or1, or2, or4, or8;
  logic         ir1, ir2, ir4, ir8;
  logic         ov1, ov2, ov4, ov8;
  logic         ol1, ol2, ol4, ol8;
  logic [5:0]   oi1, oi2, oi4, oi8;
  logic [31:0]  ow1;
  logic [63:0]  ow2;
  logic [127:0] ow4;
  logic [255:0] ow8;

  assign iv1 = in_valid && (sel == 0);
  assign iv2 = in_valid && (sel == 1);
  assign iv4 = in_valid && (sel == 2);
  assign iv8 = in_valid && (sel == 3);
  assign or1 = out_ready && (sel == 0);
  assign or2 = out_ready && (sel == 1);
  assign or4 = out_ready && (sel == 2);
  assign or8 = out_ready && (sel == 3);

  sha256_w_expander_stream #(.LANES(1)) u_l1 (
    .CLK(clk), .RST(rst), .in_valid(iv1), .in_ready(ir1), .block_in(block_in),
    .out_valid(ov1), .out_ready(or1), .out_words(ow1), .out_idx(oi1), .out_last(ol1));
  sha256_w_expander_stream #(.LANES(2)) u_l2 (
    .CLK(clk), .RST(rst), .in_valid(iv2), .in_ready(ir2), .block_in(block_in),
    .out_valid(ov2), .out_ready(or2), .out_words(ow2), .out_idx(oi2), .out_last(ol2));
  sha256_w_expander_stream #(.LANES(4)) u_l4 (
    .CLK(clk), .RST(rst), .in_valid(iv4), .in_ready(ir4), .block_in(block_in),
    .out_valid(ov4), .out_ready(or4), .out_words(ow4), .out_idx(oi4), .out_last(ol4));
  sha256_w_expander_stream #(.LANES(8)) u_l8 (
    .CLK(clk), .RST(rst), .in_valid(iv8), .in_ready(ir8), .block_in(block_in),
    .out_valid(ov8), .out_ready(or8), .out_words(ow8), .out_idx(oi8), .out_last(ol8));

  // selected instance, words left-aligned in 256 bits
  logic         o_in_ready, o_valid, o_last;
  logic [5:0]   o_idx;
  logic [255:0] o_words;

  always_comb begin
    o_in_ready = ir1; o_valid = ov1; o_last = ol1; o_idx = oi1;
    o_words = {ow1, 224'b0};
    case (sel)
      1: begin o_in_ready = ir2; o_valid = ov2; o_last = ol2; o_idx = oi2; o_words = {ow2, 192'b0}; end
      2: begin o_in_ready = ir4; o_valid = ov4; o_last = ol4; o_idx = oi4; o_words = {ow4, 128'b0}; end
      3: begin o_in_ready = ir8; o_valid = ov8; o_last = ol8; o_idx = oi8; o_words = ow8; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_w[64];
  logic [31:0] cap_w[64];
  logic [511:0] blk_tab[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) model_w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      model_w[t] = m_s1(model_w[t-2]) + model_w[t-7] + m_s0(model_w[t-15]) + model_w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back(model_w[t]);
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_stream(input int lanes, input int nblk, input bit rand_ready,
                            input int stop_idx, output int beats, output int bubbles);
    int next_blk = 0;
    int cyc = 0;
    int per_blk = 64 / lanes;
    int exp_idx;
    bit started = 0;
    bit stalled = 0;
    logic [255:0] prev_w = '0;
    logic [5:0]   prev_i = '0;
    logic         prev_l = 1'b0;
    beats = 0;
    bubbles = 0;
    for (int t = 0; t < 64; t++) cap_w[t] = '0;
    while (next_blk < nblk || exp_q.size() != 0) begin
      if (cyc > 3000) begin
        check("timeout", 32'(cyc), 32'd0);
        break;
      end
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (next_blk < nblk) begin
        in_valid = 1'b1;
        block_in = blk_tab[next_blk];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stop_idx >= 0 && o_valid && int'(o_idx) == stop_idx) return;
      check("in_ready", 32'(o_in_ready), 32'((!o_valid) || (o_last && out_ready)));
      if (stalled) begin
        check("stall_word0", o_words[255 -: 32], prev_w[255 -: 32]);
        check("stall_wordN", o_words[255-32*(lanes-1) -: 32], prev_w[255-32*(lanes-1) -: 32]);
        check("stall_idx", 32'(o_idx), 32'(prev_i));
        check("stall_last", 32'(o_last), 32'(prev_l));
      end
      if (o_valid) begin
        started = 1;
        if (out_ready) begin
          exp_idx = (beats % per_blk) * lanes;
          check("out_idx", 32'(o_idx), 32'(exp_idx));
          check("out_last", 32'(o_last), 32'(exp_idx == 64 - lanes));
          for (int j = 0; j < lanes; j++) begin
            if (exp_q.size() == 0) begin
              check("extra_word", o_words[255-32*j -: 32], 32'hxxxx_xxxx);
            end else begin
              check("word", o_words[255-32*j -: 32], exp_q.pop_front());
            end
            cap_w[(exp_idx + j) % 64] = o_words[255-32*j -: 32];
          end
          beats++;
        end
      end else if (started) begin
        bubbles++;
      end
      stalled = o_valid && !out_ready;
      prev_w = o_words;
      prev_i = o_idx;
      prev_l = o_last;
      if (in_valid && o_in_ready) begin
        push_block(blk_tab[next_blk]);
        next_blk++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic rand_block(input int slot);
    for (int w = 0; w < 16; w++) blk_tab[slot][511-32*w -: 32] = $urandom();
  endtask

  // ---------------- main sequence ----------------
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'b0, 32'h00000018};
  int beats, bubbles;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; block_in = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // reset state on every lane count
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_last", 32'(o_last), 32'd0);
      check("rst_idx", 32'(o_idx), 32'd0);
      check("rst_word0", o_words[255 -: 32], 32'd0);
      check("rst_in_ready", 32'(o_in_ready), 32'd1);
    end

    // LANES=1, "abc" block, no backpressure
    sel = 0; blk_tab[0] = ABC_BLK;
    run_stream(1, 1, 1'b0, -1, beats, bubbles);
    check("l1_beats", 32'(beats), 32'd64);
    check("l1_W16", cap_w[16], 32'h61626380);
    check("l1_W17", cap_w[17], 32'h000F0000);

    // LANES=4, same block
    sel = 2; blk_tab[0] = ABC_BLK;
    run_stream(4, 1, 1'b0, -1, beats, bubbles);
    check("l4_beats", 32'(beats), 32'd16);
    for (int t = 16; t < 20; t++) check("l4_W16_19", cap_w[t], model_w[t]);

    // LANES=2, random blocks, random backpressure
    sel = 1;
    for (int b = 0; b < 3; b++) rand_block(b);
    run_stream(2, 3, 1'b1, -1, beats, bubbles);
    check("l2_beats", 32'(beats), 32'd96);

    // LANES=8, two blocks back-to-back, no bubble expected
    sel = 3;
    rand_block(0); rand_block(1);
    run_stream(8, 2, 1'b0, -1, beats, bubbles);
    check("l8_beats", 32'(beats), 32'd16);
    check("l8_bubbles", 32'(bubbles), 32'd0);

    // LANES=1, reset pulse at out_idx=20, then a fresh block
    sel = 0; blk_tab[0] = ABC_BLK;
    run_stream(1, 1, 1'b0, 20, beats, bubbles);
    check("pre_rst_idx", 32'(o_idx), 32'd20);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_idx", 32'(o_idx), 32'd0);
    check("midrst_word0", o_words[255 -: 32], 32'd0);
    check("midrst_in_ready", 32'(o_in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #2;
    check("midrst_valid2", 32'(o_valid), 32'd0);
    rand_block(0);
    run_stream(1, 1, 1'b0, -1, beats, bubbles);
    check("post_rst_beats", 32'(beats), 32'd64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_w_expander_stream.md
SHA256_W_EXPANDER_STREAM -- requirements
Module: sha256_w_expander_stream

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving message-schedule words emitted per output beat; legal values are 1, 2, 4 and 8, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, which marks block_in as holding a valid 512-bit message block.
REQ-005 The block SHALL have port in_ready, output, 1 bit, which marks that the block accepts a message block.
REQ-006 The block SHALL have port block_in, input, 512 bits, carrying W0..W15, with W0 at [511:480] and W15 at [31:0].
REQ-007 The block SHALL have port out_valid, output, 1 bit, which marks out_words as valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit, the downstream accept signal.
REQ-009 The block SHALL have port out_words, output, LANES*32 bits, carrying the schedule words of the current beat; the lowest-index word is in the most-significant lane.
REQ-010 The block SHALL have port out_idx, output, 6 bits, giving the index t of the lowest-index word in out_words.
REQ-011 The block SHALL have port out_last, output, 1 bit, which is high on the beat carrying W63.

Function
REQ-012 The block SHALL transfer data on the in side only when in_valid and in_ready are both high in the same cycle (in-fire).
REQ-013 The block SHALL transfer data on the out side only when out_valid and out_ready are both high in the same cycle (out-fire).
REQ-014 The block SHALL have two states, IDLE and EXPAND.
REQ-015 The block SHALL leave IDLE for EXPAND on in-fire.
REQ-016 The block SHALL leave EXPAND for IDLE on an out-fire with out_last high and no simultaneous in-fire.
REQ-017 The block SHALL drive in_ready as (state==IDLE) OR (state==EXPAND AND out_last AND out_ready); it SHALL support back-to-back blocks with zero bubble.
REQ-018 On in-fire, the block SHALL load a 16-word window register with W0..W15 and clear the index counter to 0.
REQ-019 The block SHALL assert out_valid the cycle after in-fire (latency 1) and hold it high throughout EXPAND.
REQ-020 The block SHALL drive out_words, in every EXPAND cycle, from window words [0..LANES-1].
REQ-021 The block SHALL drive out_idx from the index counter.
REQ-022 The block SHALL drive out_last as (out_idx == 64-LANES).
REQ-023 On each out-fire that is not the last beat, the block SHALL shift the window down by LANES words, append LANES new words, and add LANES to the index counter.
REQ-024 The block SHALL compute each new word as W[k] = s1(W[k-2]) + W[k-7] + s0(W[k-15]) + W[k-16], modulo 2^32.
REQ-025 When k-2 falls inside the same beat (LANES>=4), the block SHALL take W[k-2] from the word computed combinationally in that beat.
REQ-026 The block SHALL implement s0(x) as ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-027 The block SHALL implement s1(x) as ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-028 The block SHALL stop appending new words once k would exceed 63; remaining lanes SHALL drain from the window unchanged.
REQ-029 The block SHALL emit exactly 64/LANES beats per block, with out_idx = 0, LANES, 2*LANES, ..., 64-LANES.
REQ-030 With out_ready low, the block SHALL hold out_words, out_idx, out_last and the window stable; backpressure SHALL never drop or duplicate a word.
REQ-031 On the last beat, an out-fire with a simultaneous in-fire SHALL reload the window, clear the index and remain in EXPAND, so that the next cycle shows the new block's W0 with out_idx=0.
REQ-032 In IDLE, the block SHALL ignore out_ready and hold out_words at its last value.

Reset
REQ-033 While RST is high at a clock edge, the block SHALL enter IDLE, clear the index counter and the window to 0, and drive out_valid=0, out_last=0, out_idx=0 and out_words=0; in_ready SHALL be 1 from the cycle after reset deasserts.
REQ-034 An RST asserted mid-EXPAND SHALL abandon the block, with no further beats for it.
REQ-035 RST SHALL take priority over a simultaneous in-fire or out-fire.

Verification
REQ-036 Directed test, LANES=1, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready held high: the bench SHALL see 64 beats, W16=0x61626380, W17=0x000F0000, out_last only at out_idx=63, and all 64 words matching a software model.
REQ-037 Directed test, LANES=4, same block: the bench SHALL see 16 beats; the beat with out_idx=16 carries W16..W19 matching the model, and out_last is high at out_idx=60.
REQ-038 Directed test, random out_ready (about 50%), LANES=2, random blocks: the bench SHALL see the output stream identical to the no-backpressure run, with outputs stable while stalled.
REQ-039 Directed test, two blocks presented back-to-back with out_ready=1, LANES=8: the bench SHALL see 16 consecutive out_valid cycles with no bubble, and out_idx wrapping 56 -> 0 on block 2.
REQ-040 Directed test, RST pulsed for 1 cycle at out_idx=20, LANES=1: the bench SHALL see out_valid=0 on the next cycle and in_ready=1 after reset deasserts, and a new block SHALL then expand correctly from W0.
REQ-041 Directed test, in_valid high during EXPAND with out_last low: the bench SHALL see in_ready=0 and the current block undisturbed.
